// File: rtl/cache_pkg.sv
// cache_pkg: geometry and refill-FSM state shared by the cache and its line-fill responder.
package cache_pkg;
    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_W       = $clog2(WORDS_PER_LINE * DATA_W / 8);
    localparam int LATENCY        = 3;

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
endpackage

// File: rtl/line_fill_responder.sv
// line_fill_responder: returns a whole cache line as address-derived word beats after a fixed latency.
module line_fill_responder
    import cache_pkg::*;
#(
    parameter int ADDR_W         = cache_pkg::ADDR_W,
    parameter int DATA_W         = cache_pkg::DATA_W,
    parameter int WORDS_PER_LINE = cache_pkg::WORDS_PER_LINE,
    parameter int LATENCY        = cache_pkg::LATENCY
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [ADDR_W-1:0]                 req_addr,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [DATA_W-1:0]                 rsp_data,
    output logic [$clog2(WORDS_PER_LINE)-1:0] rsp_beat,
    output logic                              rsp_last,
    output logic [31:0]                       refill_count
);
    localparam int BEAT_W = $clog2(WORDS_PER_LINE);
    localparam int BYTE_W = $clog2(DATA_W / 8);
    localparam int LINE_BYTES = WORDS_PER_LINE * DATA_W / 8;
    localparam int CNT_W = LATENCY > 1 ? $clog2(LATENCY) : 1;

    state_t              state;
    logic [ADDR_W-1:0]   base;
    logic [CNT_W-1:0]    cnt;
    logic [BEAT_W-1:0]   beat_nx;
    logic [ADDR_W-1:0]   req_base;

    assign beat_nx  = rsp_beat + 1'b1;
    assign req_base = req_addr & ~ADDR_W'(LINE_BYTES - 1);

    // Base has its offset bits cleared, so OR-ing the beat offset never carries out of the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            base         <= '0;
            cnt          <= '0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_beat     <= '0;
            rsp_last     <= 1'b0;
            refill_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        base         <= req_base;
                        rsp_data     <= DATA_W'(req_base);
                        rsp_beat     <= '0;
                        rsp_last     <= 1'b0;
                        refill_count <= refill_count + 32'd1;
                        req_ready    <= 1'b0;
                        cnt          <= CNT_W'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state     <= BURST;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        state     <= BURST;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                BURST: begin
                    if (rsp_ready) begin
                        if (rsp_last) begin
                            state     <= IDLE;
                            rsp_valid <= 1'b0;
                            rsp_last  <= 1'b0;
                            req_ready <= 1'b1;
                        end else begin
                            rsp_beat <= beat_nx;
                            rsp_last <= beat_nx == BEAT_W'(WORDS_PER_LINE - 1);
                            rsp_data <= DATA_W'(base | (ADDR_W'(beat_nx) << BYTE_W));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_fill_responder.sv
// tb_line_fill_responder: directed and random-trace checks of the line-fill responder.
module tb_line_fill_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_beat;
    logic        rsp_last;
    logic [31:0] refill_count;

    int errors = 0;
    int checks = 0;

    line_fill_responder dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_beat(rsp_beat), .rsp_last(rsp_last), .refill_count(refill_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present a request and hold it until the edge that accepts it; returns #1 after that edge.
    task automatic accept(input logic [31:0] addr);
        int n = 0;
        req_valid = 1'b1;
        req_addr  = addr;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("req_ready_before_accept", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = 32'hDEAD_BEEF;
    endtask

    task automatic get_burst(input logic [31:0] addr, input int nb, input int stall_beat,
                             input int stall_n, input bit rnd);
        logic [31:0] base;
        base = addr & 32'hFFFF_FFF0;
        for (int b = 0; b < nb; b++) begin
            int n;
            int st;
            n = 0;
            while (!rsp_valid && n < 20) begin
                @(posedge clk); #1; n++;
            end
            chk("rsp_valid", rsp_valid, 1'b1);
            chk("rsp_data", rsp_data, base + 32'(4 * b));
            chk("rsp_beat", rsp_beat, 32'(b));
            chk("rsp_last", rsp_last, b == 3);
            chk("req_ready_busy", req_ready, 1'b0);
            st = rnd ? int'($urandom_range(0, 2)) : (b == stall_beat ? stall_n : 0);
            if (st > 0) begin
                rsp_ready = 1'b0;
                repeat (st) begin
                    @(posedge clk); #1;
                    chk("hold_data", rsp_data, base + 32'(4 * b));
                    chk("hold_beat", rsp_beat, 32'(b));
                end
                rsp_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (nb == 4) begin
            chk("end_rsp_valid", rsp_valid, 1'b0);
            chk("end_req_ready", req_ready, 1'b1);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_count", refill_count, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_req_ready", req_ready, 1'b1);
        chk("post_rst_count", refill_count, 32'h0);

        // Single refill with latency 3: the first beat handshakes at T+3
        accept(32'h0000_1234);
        chk("lat_T", rsp_valid, 1'b0);
        @(posedge clk); #1;
        chk("lat_T1", rsp_valid, 1'b0);
        @(posedge clk); #1;
        chk("lat_T2", rsp_valid, 1'b1);
        get_burst(32'h0000_1234, 4, -1, 0, 1'b0);
        chk("count_1", refill_count, 32'd1);

        accept(32'h0000_1234);
        get_burst(32'h0000_1234, 4, 1, 2, 1'b0);
        chk("count_2", refill_count, 32'd2);

        // A request held high through a burst is only taken once the responder is idle
        accept(32'h0000_1000);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0040;
        get_burst(32'h0000_1000, 4, -1, 0, 1'b0);
        chk("ignored_count", refill_count, 32'd3);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("late_accept_count", refill_count, 32'd4);
        get_burst(32'h0000_0040, 4, -1, 0, 1'b0);
        chk("late_accept_final", refill_count, 32'd4);

        // Asynchronous reset in the middle of beat 2
        accept(32'h0000_2000);
        get_burst(32'h0000_2000, 2, -1, 0, 1'b0);
        chk("abort_beat", rsp_beat, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rsp_valid", rsp_valid, 1'b0);
        chk("abort_rsp_last", rsp_last, 1'b0);
        chk("abort_rsp_data", rsp_data, 32'h0);
        chk("abort_rsp_beat", rsp_beat, 32'h0);
        chk("abort_req_ready", req_ready, 1'b0);
        chk("abort_count", refill_count, 32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_rel_ready", req_ready, 1'b1);
        accept(32'h0000_0080);
        get_burst(32'h0000_0080, 4, -1, 0, 1'b0);

        // Top of the address space stays inside its line
        accept(32'hFFFF_FFF4);
        get_burst(32'hFFFF_FFF4, 4, -1, 0, 1'b0);
        chk("top_count", refill_count, 32'd2);

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            accept(a);
            get_burst(a, 4, -1, 0, 1'b1);
        end
        chk("trace_count", refill_count, 32'd1002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
